// File: rtl/mem_access_sequencer_if.sv
// Bundle between the memory access sequencer, the control unit that issues
// commands to it, and the unified memory port it drives.
//   master : the sequencer (takes commands, drives the memory, returns captures)
//   slave  : the environment (control unit + memory)
// Signal groups:
//   command  : cmd_valid/cmd_ready handshake, cmd_op and its address/data fields
//   memory   : pc, sr1..sr3, rd, data, two, MEMWRITE, WRITEZERO out;
//              IRO, IRT, out1..out3 back (registered inside the memory)
//   response : ir0_q, ir1_q, a_q, b_q, c_q, pc_next_q, rsp_valid, fetch_cnt
interface mem_access_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_pc;
  logic [DATA_WIDTH-1:0] cmd_sr1;
  logic [DATA_WIDTH-1:0] cmd_sr2;
  logic [DATA_WIDTH-1:0] cmd_sr3;
  logic [DATA_WIDTH-1:0] cmd_rd;
  logic [DATA_WIDTH-1:0] cmd_data;

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] sr1;
  logic [DATA_WIDTH-1:0] sr2;
  logic [DATA_WIDTH-1:0] sr3;
  logic [DATA_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] two;
  logic                  MEMWRITE;
  logic                  WRITEZERO;
  logic [DATA_WIDTH-1:0] IRO;
  logic [DATA_WIDTH-1:0] IRT;
  logic [DATA_WIDTH-1:0] out1;
  logic [DATA_WIDTH-1:0] out2;
  logic [DATA_WIDTH-1:0] out3;

  logic [DATA_WIDTH-1:0] ir0_q;
  logic [DATA_WIDTH-1:0] ir1_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] c_q;
  logic [DATA_WIDTH-1:0] pc_next_q;
  logic                  rsp_valid;
  logic [CNT_WIDTH-1:0]  fetch_cnt;

  modport master (
    input  cmd_valid, cmd_op, cmd_pc, cmd_sr1, cmd_sr2, cmd_sr3, cmd_rd, cmd_data,
    input  IRO, IRT, out1, out2, out3,
    output cmd_ready, pc, sr1, sr2, sr3, rd, data, two, MEMWRITE, WRITEZERO,
    output ir0_q, ir1_q, a_q, b_q, c_q, pc_next_q, rsp_valid, fetch_cnt
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_pc, cmd_sr1, cmd_sr2, cmd_sr3, cmd_rd, cmd_data,
    output IRO, IRT, out1, out2, out3,
    input  cmd_ready, pc, sr1, sr2, sr3, rd, data, two, MEMWRITE, WRITEZERO,
    input  ir0_q, ir1_q, a_q, b_q, c_q, pc_next_q, rsp_valid, fetch_cnt
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Initiator side of the unified memory port of the memory-memory multi-cycle
// processor. Accepts one command at a time (FETCH, READ_SRC, WRITE, WRITE_BR),
// drives address/data/strobes to a memory that reads one cycle after the
// address is applied, and captures the read data for the datapath.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mem_access_sequencer_if.master (command, memory and response groups)
// Sequences: reads  IDLE -> ADDR -> CAPT -> RESP -> IDLE
//            writes IDLE -> WR   -> RESP -> IDLE
module mem_access_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int STEP       = 2,
  parameter int CNT_WIDTH  = 8
) (
  input logic                   clk,
  input logic                   reset_n,
  mem_access_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_CAPT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [1:0] OP_FETCH    = 2'b00;
  localparam logic [1:0] OP_READ_SRC = 2'b01;
  localparam logic [1:0] OP_WRITE_BR = 2'b11;

  localparam logic [DATA_WIDTH-1:0] STEP_W    = DATA_WIDTH'(STEP);
  // A fetch consumes two instruction words, so the next PC is two steps on.
  localparam logic [DATA_WIDTH-1:0] FETCH_ADV = DATA_WIDTH'(2 * STEP);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [1:0] op;
  logic       accept;

  assign accept = bus.cmd_valid && (state == S_IDLE);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.cmd_valid) state_nxt = bus.cmd_op[1] ? S_WR : S_ADDR;
      S_ADDR:  state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_RESP;
      S_WR:    state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      op    <= OP_FETCH;
      bus.pc   <= '0;
      bus.sr1  <= '0;
      bus.sr2  <= '0;
      bus.sr3  <= '0;
      bus.rd   <= '0;
      bus.data <= '0;
      // NOTE: the capture registers are reset too: a reset must discard any
      // in-flight capture and leave the datapath seeing zeros.
      bus.ir0_q     <= '0;
      bus.ir1_q     <= '0;
      bus.a_q       <= '0;
      bus.b_q       <= '0;
      bus.c_q       <= '0;
      bus.pc_next_q <= '0;
      bus.fetch_cnt <= '0;
    end else begin
      state <= state_nxt;

      // Command fields are sampled only here; only the current op's fields
      // move, the others hold their last value.
      if (accept) begin
        op <= bus.cmd_op;
        case (bus.cmd_op)
          OP_FETCH: bus.pc <= bus.cmd_pc;
          OP_READ_SRC: begin
            bus.sr1 <= bus.cmd_sr1;
            bus.sr2 <= bus.cmd_sr2;
            bus.sr3 <= bus.cmd_sr3;
          end
          default: begin
            bus.rd   <= bus.cmd_rd;
            bus.data <= bus.cmd_data;
          end
        endcase
      end

      // Memory registered its outputs at the end of ADDR, so they are valid
      // throughout CAPT. Only read ops ever reach CAPT.
      if (state == S_CAPT) begin
        if (op == OP_FETCH) begin
          bus.ir0_q     <= bus.IRO;
          bus.ir1_q     <= bus.IRT;
          bus.pc_next_q <= bus.pc + FETCH_ADV;
          if (bus.fetch_cnt != CNT_MAX) bus.fetch_cnt <= bus.fetch_cnt + CNT_WIDTH'(1);
        end else begin
          bus.a_q <= bus.out1;
          bus.b_q <= bus.out2;
          bus.c_q <= bus.out3;
        end
      end
    end
  end

  // Strobes and handshake are decoded from the state register, so they fall
  // the instant reset_n is asserted.
  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.MEMWRITE  = (state == S_WR);
  assign bus.WRITEZERO = (state == S_WR) && (op == OP_WRITE_BR);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.two       = STEP_W;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: a word memory driven by the
// DUT's own strobes, a transaction-level reference model, a per-cycle compare
// process and directed plus randomized command streams.
module tb_mem_access_sequencer;

  localparam logic [1:0] FETCH = 2'b00, READ_SRC = 2'b01, WRITE = 2'b10, WRITE_BR = 2'b11;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_sequencer_if #(.DATA_WIDTH(16), .CNT_WIDTH(8)) bus();

  mem_access_sequencer #(.DATA_WIDTH(16), .STEP(2), .CNT_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] widx(input logic [15:0] a);
    return a[6:1];
  endfunction

  // Memory: synchronous read of every port, write on the edge while strobed.
  logic [15:0] ram [64];
  initial for (int i = 0; i < 64; i++) ram[i] = '0;

  always @(posedge clk) begin
    if (bus.MEMWRITE) ram[widx(bus.rd)] <= bus.data;
    if (bus.WRITEZERO) ram[widx(bus.rd + bus.two)] <= '0;
    bus.IRO  <= ram[widx(bus.pc)];
    bus.IRT  <= ram[widx(bus.pc + bus.two)];
    bus.out1 <= ram[widx(bus.sr1)];
    bus.out2 <= ram[widx(bus.sr2)];
    bus.out3 <= ram[widx(bus.sr3)];
  end

  // Reference model: memory contents by command, and a timeline of the
  // current op as "edges since accept" (reads last 3 cycles, writes 2).
  logic [15:0] ref_mem [64];
  initial for (int i = 0; i < 64; i++) ref_mem[i] = '0;

  bit          m_busy;
  logic [1:0]  m_k, m_op;
  logic [15:0] m_pc, m_sr1, m_sr2, m_sr3, m_rd, m_data;
  logic [15:0] m_ir0, m_ir1, m_pcn, m_a, m_b, m_c;
  logic [15:0] p_ir0, p_ir1, p_pcn, p_a, p_b, p_c;
  logic [7:0]  m_cnt;
  int          m_acc = 0;

  function automatic logic [1:0] last_k(input logic [1:0] op);
    return op[1] ? 2'd1 : 2'd2;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_k <= '0; m_op <= '0;
      m_pc <= '0; m_sr1 <= '0; m_sr2 <= '0; m_sr3 <= '0; m_rd <= '0; m_data <= '0;
      m_ir0 <= '0; m_ir1 <= '0; m_pcn <= '0; m_a <= '0; m_b <= '0; m_c <= '0;
      m_cnt <= '0;
    end else if (m_busy) begin
      if (m_op[1] && m_k == 2'd0) begin
        ref_mem[widx(m_rd)] <= m_data;
        if (m_op == WRITE_BR) ref_mem[widx(m_rd + 16'd2)] <= '0;
      end
      if (!m_op[1] && m_k == 2'd1) begin
        if (m_op == FETCH) begin
          m_ir0 <= p_ir0; m_ir1 <= p_ir1; m_pcn <= p_pcn;
          if (m_cnt != 8'd255) m_cnt <= m_cnt + 8'd1;
        end else begin
          m_a <= p_a; m_b <= p_b; m_c <= p_c;
        end
      end
      if (m_k == last_k(m_op)) m_busy <= 1'b0;
      else m_k <= m_k + 2'd1;
    end else if (bus.cmd_valid) begin
      m_busy <= 1'b1; m_k <= '0; m_op <= bus.cmd_op; m_acc <= m_acc + 1;
      case (bus.cmd_op)
        FETCH: begin
          m_pc  <= bus.cmd_pc;
          p_ir0 <= ref_mem[widx(bus.cmd_pc)];
          p_ir1 <= ref_mem[widx(bus.cmd_pc + 16'd2)];
          p_pcn <= bus.cmd_pc + 16'd4;
        end
        READ_SRC: begin
          m_sr1 <= bus.cmd_sr1; m_sr2 <= bus.cmd_sr2; m_sr3 <= bus.cmd_sr3;
          p_a <= ref_mem[widx(bus.cmd_sr1)];
          p_b <= ref_mem[widx(bus.cmd_sr2)];
          p_c <= ref_mem[widx(bus.cmd_sr3)];
        end
        default: begin
          m_rd <= bus.cmd_rd; m_data <= bus.cmd_data;
        end
      endcase
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    check("cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy));
    check("MEMWRITE",  32'(bus.MEMWRITE),  32'(m_busy && m_op[1] && m_k == 2'd0));
    check("WRITEZERO", 32'(bus.WRITEZERO), 32'(m_busy && m_op == WRITE_BR && m_k == 2'd0));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_busy && m_k == last_k(m_op)));
    check("two",       32'(bus.two),       32'd2);
    check("pc",        32'(bus.pc),        32'(m_pc));
    check("sr1",       32'(bus.sr1),       32'(m_sr1));
    check("sr2",       32'(bus.sr2),       32'(m_sr2));
    check("sr3",       32'(bus.sr3),       32'(m_sr3));
    check("rd",        32'(bus.rd),        32'(m_rd));
    check("data",      32'(bus.data),      32'(m_data));
    check("ir0_q",     32'(bus.ir0_q),     32'(m_ir0));
    check("ir1_q",     32'(bus.ir1_q),     32'(m_ir1));
    check("pc_next_q", 32'(bus.pc_next_q), 32'(m_pcn));
    check("a_q",       32'(bus.a_q),       32'(m_a));
    check("b_q",       32'(bus.b_q),       32'(m_b));
    check("c_q",       32'(bus.c_q),       32'(m_c));
    check("fetch_cnt", 32'(bus.fetch_cnt), 32'(m_cnt));
  end

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!m_busy) return;
      @(posedge clk); #1;
    end
    check("idle_timeout", 32'(m_busy), 32'd0);
  endtask

  // Present a command with unrelated fields randomized; returns #1 after the
  // accept edge. wait_done: drop cmd_valid, check latency (edges counted from
  // the accept edge inclusive) and wait for the op to finish.
  task automatic send(input logic [1:0] op, input logic [15:0] f0, input logic [15:0] f1,
                      input logic [15:0] f2, input bit wait_done);
    int n, lat;
    bit ok;
    bus.cmd_op   = op;
    bus.cmd_pc   = 16'($urandom); bus.cmd_sr1 = 16'($urandom);
    bus.cmd_sr2  = 16'($urandom); bus.cmd_sr3 = 16'($urandom);
    bus.cmd_rd   = 16'($urandom); bus.cmd_data = 16'($urandom);
    case (op)
      FETCH:    bus.cmd_pc = f0;
      READ_SRC: begin bus.cmd_sr1 = f0; bus.cmd_sr2 = f1; bus.cmd_sr3 = f2; end
      default:  begin bus.cmd_rd = f0; bus.cmd_data = f1; end
    endcase
    bus.cmd_valid = 1'b1;
    n = m_acc;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (m_acc != n);
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    if (wait_done) begin
      bus.cmd_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      check("latency", 32'(lat), op[1] ? 32'd2 : 32'd3);
      wait_idle();
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0;
    bus.cmd_pc = '0; bus.cmd_sr1 = '0; bus.cmd_sr2 = '0; bus.cmd_sr3 = '0;
    bus.cmd_rd = '0; bus.cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_two", 32'(bus.two), 32'd2);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk) reset_n = 1'b1;

    // Reset in the middle of a write.
    send(WRITE, 16'd0, 16'd99, 16'd0, 1'b0);
    bus.cmd_valid = 1'b0;
    check("wr_memwrite_high", 32'(bus.MEMWRITE), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_memwrite", 32'(bus.MEMWRITE), 32'd0);
    check("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_mid_two", 32'(bus.two), 32'd2);
    @(negedge clk) reset_n = 1'b1;

    // Writes then fetch.
    send(WRITE, 16'd0, 16'd5, 16'd0, 1'b1);
    send(WRITE, 16'd2, 16'd10, 16'd0, 1'b1);
    send(FETCH, 16'd0, 16'd0, 16'd0, 1'b1);
    check("fetch_ir0", 32'(bus.ir0_q), 32'd5);
    check("fetch_ir1", 32'(bus.ir1_q), 32'd10);
    check("fetch_pcn", 32'(bus.pc_next_q), 32'd4);
    check("fetch_cnt1", 32'(bus.fetch_cnt), 32'd1);

    // Source read.
    send(WRITE, 16'd4, 16'd13, 16'd0, 1'b1);
    send(WRITE, 16'd6, 16'd27, 16'd0, 1'b1);
    send(READ_SRC, 16'd2, 16'd4, 16'd6, 1'b1);
    check("src_a", 32'(bus.a_q), 32'd10);
    check("src_b", 32'(bus.b_q), 32'd13);
    check("src_c", 32'(bus.c_q), 32'd27);

    // Branch write zeroes the following word.
    send(WRITE_BR, 16'd0, 16'd56, 16'd0, 1'b1);
    send(READ_SRC, 16'd0, 16'd2, 16'd6, 1'b1);
    check("br_a", 32'(bus.a_q), 32'd56);
    check("br_b", 32'(bus.b_q), 32'd0);
    check("br_c", 32'(bus.c_q), 32'd27);

    // Busy: second command held while the first runs; cmd_pc changes at once.
    send(FETCH, 16'd8, 16'd0, 16'd0, 1'b0);
    send(FETCH, 16'd20, 16'd0, 16'd0, 1'b0);
    check("busy_first_pcn", 32'(bus.pc_next_q), 32'd12);
    check("busy_second_pc", 32'(bus.pc), 32'd20);
    bus.cmd_valid = 1'b0;
    wait_idle();
    check("busy_second_pcn", 32'(bus.pc_next_q), 32'd24);
    check("busy_cnt", 32'(bus.fetch_cnt), 32'd3);

    // Wrap-around.
    send(FETCH, 16'hFFFC, 16'd0, 16'd0, 1'b1);
    check("wrap_pcn", 32'(bus.pc_next_q), 32'd0);

    // Randomized stream, sometimes holding cmd_valid into the next command.
    for (int i = 0; i < 300; i++) begin
      logic [1:0] op;
      bit hold;
      op = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 3) == 0) && (i < 299);
      send(op, {9'd0, 6'($urandom_range(0, 63)), 1'b0}, op[1] ? 16'($urandom) :
           {9'd0, 6'($urandom_range(0, 63)), 1'b0}, {9'd0, 6'($urandom_range(0, 63)), 1'b0},
           !hold);
      if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Saturation of the fetch counter.
    for (int i = 0; i < 260; i++)
      send(FETCH, {9'd0, 6'($urandom_range(0, 63)), 1'b0}, 16'd0, 16'd0, 1'b1);
    check("sat_cnt", 32'(bus.fetch_cnt), 32'd255);

    // Reset during CAPT discards the capture and clears the captured state.
    send(FETCH, 16'd0, 16'd0, 16'd0, 1'b0);
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("rst_capt_ir0", 32'(bus.ir0_q), 32'd0);
    check("rst_capt_pcn", 32'(bus.pc_next_q), 32'd0);
    check("rst_capt_cnt", 32'(bus.fetch_cnt), 32'd0);
    check("rst_capt_rsp", 32'(bus.rsp_valid), 32'd0);
    check("rst_capt_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Initiator side of the unified memory port in the memory-memory multi-cycle processor.
- Takes one command at a time from the control unit: instruction fetch, three-source operand read, result write, or branch write with zero.
- Drives the memory address, data and write strobes, then captures the memory outputs into holding registers for the datapath.
- The memory reads synchronously, one cycle after the address is applied, and writes on the rising clk edge while MEMWRITE=1.

Parameters:
DATA_WIDTH, 16, width of data and address words
STEP, 2, address distance between consecutive words; driven on two
CNT_WIDTH, 8, width of the fetch counter

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command (IDLE only)
cmd_op  in  2  00 FETCH, 01 READ_SRC, 10 WRITE, 11 WRITE_BR
cmd_pc  in  DATA_WIDTH  fetch address
cmd_sr1, cmd_sr2, cmd_sr3  in  DATA_WIDTH  source addresses
cmd_rd  in  DATA_WIDTH  destination address
cmd_data  in  DATA_WIDTH  write data
pc, sr1, sr2, sr3, rd, data  out  DATA_WIDTH  to memory
two  out  DATA_WIDTH  word step to memory, constant STEP
MEMWRITE  out  1  memory write strobe
WRITEZERO  out  1  branch zero-write strobe
IRO, IRT, out1, out2, out3  in  DATA_WIDTH  memory read data
ir0_q, ir1_q  out  DATA_WIDTH  captured instruction words
a_q, b_q, c_q  out  DATA_WIDTH  captured operands
pc_next_q  out  DATA_WIDTH  fetch address + 2*STEP
rsp_valid  out  1  one-cycle completion pulse
fetch_cnt  out  CNT_WIDTH  count of completed fetches, saturating

Behaviour:
- Reset values (asynchronous, immediate on reset_n=0):
  - All data and address outputs and all captured registers = 0.
  - two = STEP.
  - MEMWRITE = 0, WRITEZERO = 0, rsp_valid = 0, fetch_cnt = 0.
  - State = IDLE, cmd_ready = 1.
- States: IDLE, ADDR, CAPT, WR, RESP.
- Command accept: accept happens on the edge where cmd_valid=1 and cmd_ready=1. Call this edge E0.
  - FETCH: register pc <= cmd_pc.
  - READ_SRC: register sr1/sr2/sr3 <= cmd_sr1/2/3.
  - WRITE and WRITE_BR: register rd <= cmd_rd and data <= cmd_data.
- Command fields are sampled only at accept. Later changes have no effect.
- Read ops (FETCH, READ_SRC): IDLE -> ADDR -> CAPT -> RESP -> IDLE.
  - At E1 (end of ADDR) the memory registers its outputs.
  - At E2 (end of CAPT) the sequencer captures:
    - FETCH: ir0_q <= IRO, ir1_q <= IRT, pc_next_q <= pc + 2*STEP (mod 2^DATA_WIDTH), fetch_cnt increments.
    - READ_SRC: a_q <= out1, b_q <= out2, c_q <= out3.
  - rsp_valid = 1 during RESP (cycle E2-E3).
- Write ops: IDLE -> WR -> RESP -> IDLE.
  - MEMWRITE = 1 for exactly the WR cycle (E0-E1).
  - WRITEZERO = 1 in the same cycle, for WRITE_BR only.
  - rsp_valid = 1 during RESP (cycle E1-E2).
- Latency from accept to rsp_valid rising: 3 cycles for reads, 2 cycles for writes.
- Strobes: MEMWRITE and WRITEZERO are 0 in every state except WR. They never assert for read ops.
- Address hold: address and data outputs keep their last value outside an operation. Only the fields of the current op are updated.
- Captured registers keep their value until overwritten by the same op type.
- cmd_valid while busy: cmd_ready=0, so the command is not accepted. The initiator must hold it. Back-to-back accept is possible at the RESP -> IDLE edge + 1 (IDLE lasts at least 1 cycle).
- Wrap-around: pc_next_q for cmd_pc = 16'hFFFC is 16'h0000. fetch_cnt saturates at 2^CNT_WIDTH-1 and does not wrap.
- Reset mid-operation: MEMWRITE, WRITEZERO and rsp_valid drop to 0 asynchronously, and the state returns to IDLE. An in-flight capture is discarded and the captured registers return to 0.

Test Plan:
- Reset mid-write: assert reset_n=0 during WR -> MEMWRITE=0 immediately, then cmd_ready=1, all captured regs 0, two=2.
- WRITE sequence: WRITE rd=0 data=5, then WRITE rd=2 data=10, then FETCH pc=0 -> each write gives MEMWRITE high exactly 1 cycle. After the fetch, rsp_valid pulses 3 cycles after accept with ir0_q=5, ir1_q=10, pc_next_q=4, fetch_cnt=1.
- Source read: WRITE 13@4 and 27@6, then READ_SRC sr1=2 sr2=4 sr3=6 -> a_q=10, b_q=13, c_q=27; MEMWRITE stays 0 throughout.
- Branch write: WRITE_BR rd=0 data=56, then READ_SRC sr1=0 sr2=2 sr3=6 -> MEMWRITE=WRITEZERO=1 for one cycle; a_q=56, b_q=0, c_q=27.
- Busy and sampling: hold cmd_valid with a second command during an active op, and change cmd_pc after accept -> second command accepted only after RESP; first op uses the originally sampled cmd_pc.
- Wrap and saturation: FETCH cmd_pc=16'hFFFC -> pc_next_q=0. Issue 256 fetches with CNT_WIDTH=8 -> fetch_cnt=255 and holds.
